// File: rtl/tx_polyphase_interp_pkg.sv
// Shared constants for the 4x polyphase pulse-shaping interpolator: prototype
// taps, lane geometry, output saturation limits and the output saturator.
package tx_polyphase_interp_pkg;

  localparam int COEFF_LEN      = 81;
  localparam int UPSAMPLE       = 4;
  localparam int NUM_LANES      = 6;
  localparam int TAPS_PER_PHASE = 21;

  // Flat coefficient used by the overflow build; large enough that a
  // full-scale input drives every phase past the 1s17 output range.
  localparam int TEST_COEFF = 16384;

  localparam logic signed [17:0] SAT_POS = 18'sh1ffff;
  localparam logic signed [17:0] SAT_NEG = 18'sh20000;

  // Symmetric prototype, centre tap H[40].
  localparam int H_TABLE [COEFF_LEN] = '{
    10, 25, 40, 40, 20, -30, -90, -140, -150, -100,
    0, 130, 250, 300, 250, 100, -150, -400, -600, -600,
    -400, 0, 500, 1000, 1300, 1200, 600, -500, -1800, -2900,
    -3400, -2900, -1100, 2100, 6800, 12800, 19400, 25800, 31200, 34800,
    36068,
    34800, 31200, 25800, 19400, 12800, 6800, 2100, -1100, -2900, -3400,
    -2900, -1800, -500, 600, 1200, 1300, 1000, 500, 0, -400,
    -600, -600, -400, -150, 100, 250, 300, 250, 130, 0,
    -100, -150, -140, -90, -30, 20, 40, 40, 25, 10
  };

  // Keep bits 34:17 when the top four bits agree, otherwise clip to the rail.
  function automatic logic signed [17:0] sat_sum(input logic signed [37:0] v);
    logic unused_lsb;
    unused_lsb = ^v[16:0];
    if (v[37:34] == {4{v[37]}}) return v[34:17];
    else if (v[37]) return SAT_NEG;
    else return SAT_POS;
  endfunction

endpackage

// File: rtl/tx_polyphase_interp_coeff_rom.sv
// Per-lane coefficient lookup: maps (phase, lane, slot) onto the prototype tap
// H[4(4L+slot)+phase], returning 0 past the delay line or the table end.
module tx_coeff_rom
  import tx_polyphase_interp_pkg::*;
#(
  parameter bit TEST_H = 1'b0
) (
  input  logic [1:0]         phase_i,
  input  logic [2:0]         lane_i,
  input  logic [1:0]         cyc_i,
  output logic signed [17:0] coeff_o
);

  logic [4:0] sym_idx;
  logic [6:0] tap_idx;

  always_comb begin
    sym_idx = {lane_i, 2'b00} + {3'b000, cyc_i};
    tap_idx = {sym_idx, 2'b00} + {5'b00000, phase_i};
    coeff_o = '0;
    if (sym_idx < 5'(TAPS_PER_PHASE) && tap_idx < 7'(COEFF_LEN)) begin
      coeff_o = TEST_H ? 18'(TEST_COEFF) : 18'(H_TABLE[tap_idx]);
    end
  end

endmodule

// File: rtl/tx_polyphase_interp.sv
// 4x polyphase interpolating pulse shaper: six time-shared MAC lanes walk the
// 21-symbol delay line over four slots per output sample.
module tx_polyphase_interp
  import tx_polyphase_interp_pkg::NUM_LANES, tx_polyphase_interp_pkg::sat_sum;
#(
  parameter int COEFF_LEN = tx_polyphase_interp_pkg::COEFF_LEN,
  parameter int UPSAMPLE  = tx_polyphase_interp_pkg::UPSAMPLE,
  parameter bit TEST_H    = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sym_clk_en,
  input  logic               sam_clk_en,
  input  logic signed [17:0] x_in,
  output logic signed [17:0] y,
  output logic [1:0]         phase
);

  localparam int TAPS_PER_PHASE = (COEFF_LEN + UPSAMPLE - 1) / UPSAMPLE;

  logic signed [17:0] s_q [TAPS_PER_PHASE];
  logic [1:0]         phase_q, phase_d;
  logic [1:0]         cyc_q, cyc_d;
  logic signed [37:0] acc_q [NUM_LANES];
  logic signed [37:0] acc_d [NUM_LANES];
  logic signed [37:0] sum_q, sum_d;
  logic signed [17:0] y_q, y_d;

  logic signed [17:0] coeff [NUM_LANES];
  logic signed [17:0] samp  [NUM_LANES];
  logic signed [35:0] prod  [NUM_LANES];

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    tx_coeff_rom #(.TEST_H(TEST_H)) u_rom (
      .phase_i (phase_q),
      .lane_i  (3'(l)),
      .cyc_i   (cyc_q),
      .coeff_o (coeff[l])
    );
  end

  // Lane L handles delay-line entry UPSAMPLE*L + slot; entries past the end read 0.
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      samp[l] = '0;
      for (int k = 0; k < TAPS_PER_PHASE; k++) begin
        if (k == UPSAMPLE * l + int'(cyc_q)) samp[l] = s_q[k];
      end
      prod[l] = 36'(samp[l]) * 36'(coeff[l]);
    end
  end

  always_comb begin
    sum_d = sum_q;
    for (int l = 0; l < NUM_LANES; l++) begin
      acc_d[l] = (cyc_q == 2'd0) ? 38'(prod[l]) : acc_q[l] + 38'(prod[l]);
    end
    // Slot 0 of a period is the one cycle where the lanes still hold the last phase.
    if (cyc_q == 2'd0) begin
      sum_d = '0;
      for (int l = 0; l < NUM_LANES; l++) sum_d = sum_d + acc_q[l];
    end

    phase_d = phase_q;
    cyc_d   = (cyc_q == 2'd3) ? cyc_q : cyc_q + 2'd1;
    y_d     = y_q;
    if (sam_clk_en) begin
      cyc_d   = 2'd0;
      phase_d = sym_clk_en ? 2'd0 : phase_q + 2'd1;
      y_d     = sat_sum(sum_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < TAPS_PER_PHASE; k++) s_q[k] <= '0;
      for (int l = 0; l < NUM_LANES; l++) acc_q[l] <= '0;
      sum_q   <= '0;
      y_q     <= '0;
      phase_q <= '0;
      cyc_q   <= '0;
    end else begin
      if (sym_clk_en) begin
        s_q[0] <= x_in;
        for (int k = 1; k < TAPS_PER_PHASE; k++) s_q[k] <= s_q[k-1];
      end
      for (int l = 0; l < NUM_LANES; l++) acc_q[l] <= acc_d[l];
      sum_q   <= sum_d;
      y_q     <= y_d;
      phase_q <= phase_d;
      cyc_q   <= cyc_d;
    end
  end

  assign y     = y_q;
  assign phase = phase_q;

endmodule

// File: tb/tb_tx_polyphase_interp.sv
// Bench for tx_polyphase_interp: strobe-level reference model plus table-driven
// phase vectors and directed impulse / DC / saturation / reset / early-strobe runs.
module tb_tx_polyphase_interp;
  import tx_polyphase_interp_pkg::*;

  typedef struct {
    int gap;
    bit sym;
    int x;
    int exp_phase;
  } vec_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               sym_clk_en = 1'b0;
  logic               sam_clk_en = 1'b0;
  logic signed [17:0] x_in = '0;
  logic signed [17:0] y, y_sat;
  logic [1:0]         phase, phase_sat;

  tx_polyphase_interp dut (
    .clk(clk), .reset(reset), .sym_clk_en(sym_clk_en), .sam_clk_en(sam_clk_en),
    .x_in(x_in), .y(y), .phase(phase)
  );

  tx_polyphase_interp #(.TEST_H(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .sym_clk_en(sym_clk_en), .sam_clk_en(sam_clk_en),
    .x_in(x_in), .y(y_sat), .phase(phase_sat)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: symbol history, phase, and the two-deep output pipeline
  int     s_m [21];
  int     phase_m = 0;
  int     per_len = 0;
  longint y_m = 0, ys_m = 0, prev_m = 0, prevs_m = 0;

  // scoreboard for the impulse response
  logic [17:0] exp_q [$];
  bit          imp_on = 1'b0;
  int          imp_cnt = 0;

  function automatic longint sat_ref(longint v);
    longint lim;
    lim = longint'(1) << 34;
    if (v >= lim) return 131071;
    if (v < -lim) return -131072;
    return v >>> 17;
  endfunction

  // Output of one sample period lasting n clocks: slot c of the symbol index
  // k (c = k mod 4) is visited once if n > c, slot 3 repeats while it lingers.
  function automatic longint period_value(bit test, int n);
    longint acc;
    int     w, m, c;
    acc = 0;
    for (int k = 0; k < 21; k++) begin
      m = 4 * k + phase_m;
      c = k % 4;
      if (m <= 80) begin
        if (c < 3) w = (n > c) ? 1 : 0;
        else       w = (n > 3) ? n - 3 : 0;
        acc += longint'(w) * longint'(s_m[k]) * longint'(test ? TEST_COEFF : H_TABLE[m]);
      end
    end
    return sat_ref(acc);
  endfunction

  task automatic check(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: one clock with the given inputs, model update, then compare
  task automatic tick(bit rst, bit sam, bit sym, int x);
    reset = rst; sam_clk_en = sam; sym_clk_en = sym; x_in = 18'(x);
    @(posedge clk);
    if (rst) begin
      foreach (s_m[k]) s_m[k] = 0;
      phase_m = 0; per_len = 0;
      y_m = 0; ys_m = 0; prev_m = 0; prevs_m = 0;
    end else begin
      per_len++;
      if (sam) begin
        y_m     = prev_m;
        ys_m    = prevs_m;
        prev_m  = period_value(1'b0, per_len);
        prevs_m = period_value(1'b1, per_len);
        phase_m = sym ? 0 : (phase_m + 1) % 4;
        per_len = 0;
      end
      if (sym) begin
        for (int k = 20; k > 0; k--) s_m[k] = s_m[k-1];
        s_m[0] = x;
      end
    end
    #1;
    check("y", y, y_m);
    check("y_sat", y_sat, ys_m);
    check("phase", phase, phase_m);
  endtask

  task automatic strobe(int gap, bit sym, int x);
    logic signed [17:0] e;
    for (int i = 1; i < gap; i++) tick(1'b0, 1'b0, 1'b0, 0);
    tick(1'b0, 1'b1, sym, x);
    if (imp_on) begin
      imp_cnt++;
      if (imp_cnt >= 2 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("impulse", y, e);
      end
    end
  endtask

  task automatic symbol(int x);
    strobe(4, 1'b1, x);
    for (int j = 0; j < 3; j++) strobe(4, 1'b0, 0);
  endtask

  function automatic int rand_sym();
    return int'($urandom_range(0, 262143)) - 131072;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   vecs [16];
    longint dc_exp [4];
    longint acc, part_exp;
    int     gap;

    vecs = '{
      '{4, 1'b1,   100, 0}, '{4, 1'b0, 0, 1}, '{4, 1'b0, 0, 2}, '{4, 1'b0, 0, 3},
      '{4, 1'b1,  -200, 0}, '{4, 1'b0, 0, 1}, '{4, 1'b1, 3000, 0}, '{4, 1'b0, 0, 1},
      '{4, 1'b0, 0, 2},     '{4, 1'b0, 0, 3}, '{4, 1'b0, 0, 0},    '{4, 1'b0, 0, 1},
      '{4, 1'b1, 0, 0},     '{4, 1'b0, 0, 1}, '{4, 1'b0, 0, 2},    '{4, 1'b0, 0, 3}
    };

    // reset state
    repeat (3) tick(1'b1, 1'b0, 1'b0, 0);
    check("reset_cyc", dut.cyc_q, 0);
    check("reset_y", y, 0);

    // phase tracking, including an early symbol strobe and a free 3->0 wrap
    foreach (vecs[i]) begin
      strobe(vecs[i].gap, vecs[i].sym, vecs[i].x);
      check("phase_tab", phase, vecs[i].exp_phase);
    end

    // impulse response from an all-zero history
    tick(1'b1, 1'b0, 1'b0, 0);
    symbol(0);
    for (int m = 0; m < 81; m++) exp_q.push_back(18'(H_TABLE[m] >>> 1));
    imp_on = 1'b1;
    imp_cnt = -1;
    symbol(65536);
    repeat (21) symbol(0);
    imp_on = 1'b0;
    check("impulse_drain", exp_q.size(), 0);

    // DC steady state per phase
    for (int p = 0; p < 4; p++) begin
      acc = 0;
      for (int k = 0; k < 21; k++)
        if (4 * k + p <= 80) acc += longint'(H_TABLE[4 * k + p]) * 32768;
      dc_exp[p] = acc >>> 17;
    end
    repeat (24) symbol(32768);
    for (int i = 0; i < 8; i++) begin
      strobe(4, (i % 4) == 0, 32768);
      check("dc", y, dc_exp[(phase_m + 2) % 4]);
    end

    // saturation on the overflow build, both rails
    repeat (24) symbol(131071);
    for (int i = 0; i < 4; i++) begin
      strobe(4, i == 0, 131071);
      check("sat_pos", y_sat, 131071);
    end
    repeat (24) symbol(-131072);
    for (int i = 0; i < 4; i++) begin
      strobe(4, i == 0, -131072);
      check("sat_neg", y_sat, -131072);
    end

    // reset in the middle of an accumulation (slot 2)
    repeat (5) symbol(rand_sym());
    strobe(4, 1'b0, 0);
    tick(1'b0, 1'b0, 1'b0, 0);
    tick(1'b0, 1'b0, 1'b0, 0);
    check("mid_cyc_before", dut.cyc_q, 2);
    tick(1'b1, 1'b0, 1'b0, 0);
    check("rst_cyc", dut.cyc_q, 0);
    check("rst_y", y, 0);
    check("rst_phase", phase, 0);
    for (int i = 0; i < 40; i++) begin
      strobe(4, (i % 4) == 0, 0);
      check("rst_zero_y", y, 0);
    end

    // early sample strobes after 2 and 3 clocks
    repeat (22) symbol(rand_sym());
    strobe(4, 1'b1, rand_sym());
    strobe(4, 1'b0, 0);
    strobe(2, 1'b0, 0);
    check("early_cyc", dut.cyc_q, 0);
    part_exp = prev_m;
    strobe(4, 1'b0, 0);
    check("early_partial", y, part_exp);
    strobe(4, 1'b1, rand_sym());
    strobe(3, 1'b0, 0);
    part_exp = prev_m;
    strobe(4, 1'b0, 0);
    check("early3_partial", y, part_exp);
    strobe(4, 1'b0, 0);

    // randomized symbols with occasional early sample strobes
    for (int s = 0; s < 40; s++) begin
      strobe(4, 1'b1, rand_sym());
      for (int j = 0; j < 3; j++) begin
        gap = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 3)) : 4;
        strobe(gap, 1'b0, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tx_polyphase_interp.md
TX_POLYPHASE_INTERP -- requirements
Module: tx_polyphase_interp

Interface
REQ-001 The block SHALL take parameters COEFF_LEN = 81 (prototype taps) and UPSAMPLE = 4 (samples per symbol); no other values are supported.
REQ-002 The block SHALL expose these ports: clk, input, 1, system clock (4x sample rate); reset, input, 1, synchronous active-high reset.
REQ-003 The block SHALL expose these ports: sym_clk_en, input, 1, symbol strobe; sam_clk_en, input, 1, sample strobe.
REQ-004 The block SHALL expose these ports: x_in, input, signed 18 (1s17), symbol; y, output, signed 18 (1s17), shaped sample; phase, output, 2, current polyphase branch.
REQ-005 The block SHALL use one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-006 The block SHALL implement y[n] = sum over k=0..20 of s[k]*H[4k+p], where p = phase, s = symbol delay line, and H[m] = 0 for m > 80. This is the zero-stuffed-by-4 81-tap pulse-shaping filter.
REQ-007 Symbol delay line s[0..20], 18 bits each: on a cycle with sym_clk_en, s[0] SHALL load x_in and s[k] SHALL load s[k-1]; otherwise it SHALL hold.
REQ-008 phase: on a sam_clk_en cycle, phase SHALL load 0 if sym_clk_en is also high, else phase+1 (wrapping 3->0).
REQ-009 Slot counter cyc (2 bits): it SHALL load 0 on a sam_clk_en cycle, else increment, saturating at 3. The four cycles following each sam_clk_en are therefore cyc = 0..3.
REQ-010 The block SHALL use six MAC lanes L = 0..5. In slot c, lane L SHALL multiply s[4L+c] by H[4(4L+c)+p]. The product SHALL be forced to 0 when 4L+c > 20 or the tap index exceeds 80.
REQ-011 Products SHALL be 36 bits; accumulators SHALL be 38 bits, sign-extended. At cyc = 0 an accumulator SHALL load its product; at cyc = 1..3 it SHALL add its product.
REQ-012 During the cycle with cyc = 0, sum_reg (38 bits) SHALL register the sum of all six accumulators, which then hold the completed previous phase.
REQ-013 On each sam_clk_en, y SHALL load sat(sum_reg); otherwise y SHALL hold.
REQ-014 sat(): when sum_reg[37:34] are all equal, the result SHALL be sum_reg[34:17]. Otherwise it SHALL be +131071 for positive sums and -131072 for negative sums.
REQ-015 Latency: the output for phase p of symbol S SHALL appear on y at the second sam_clk_en after the sam_clk_en on which that phase was selected.
REQ-016 Strobe contract: sam_clk_en every 4 clk; sym_clk_en every 16 clk and always coincident with sam_clk_en. A sym_clk_en without sam_clk_en SHALL shift the delay line only.
REQ-017 An early sam_clk_en (spacing under 4 clk) SHALL restart cyc at 0. The partial accumulation from the interrupted period SHALL be the value taken into sum_reg; no error flag is raised.
REQ-018 phase SHALL be driven from the internal phase register with no extra delay.

Reset
REQ-019 While reset is high at a clk edge, the block SHALL clear s[], accumulators, sum_reg, y, phase and cyc to 0, overriding all enables.
REQ-020 Reset asserted mid-accumulation SHALL discard all in-flight work. The first post-reset sample SHALL be computed from an all-zero history.

Structure
REQ-021 The shared package SHALL hold the 81-entry H table (signed 18-bit, symmetric, H[40] = 36068), COEFF_LEN, UPSAMPLE, the lane count (6) and the saturation limits.
REQ-022 The block SHALL contain one sub-module, tx_coeff_rom. It SHALL be combinational, map (phase, lane, cyc) to H[4(4L+cyc)+phase] or 0, and be instantiated once per lane.

Verification
REQ-023 Impulse: a single symbol 65536 followed by zeros -> y SHALL equal H[m]/2 (truncated toward -inf) for m = 0..80 on consecutive samples, starting 2 samples after the load.
REQ-024 DC: all symbols = 32768 -> after 21 symbols, the steady-state y per phase SHALL equal (sum over k of H[4k+p]*32768)>>17 for each p.
REQ-025 Saturation: all symbols = +131071 with a test H scaled to overflow -> y SHALL equal 131071; with all symbols = -131072 -> y SHALL equal -131072, with no wrap.
REQ-026 Reset mid-stream: assert reset for 1 clk with cyc = 2 -> y = 0, phase = 0 and cyc = 0 next cycle. Zero input afterward SHALL produce y = 0 indefinitely.
REQ-027 Phase tracking: sym_clk_en every 16 clk -> phase SHALL read 0,1,2,3 on successive samples. A sym_clk_en inserted on a sample strobe early SHALL force phase to 0.
REQ-028 Early strobe: sam_clk_en after 2 clk -> cyc SHALL restart at 0. The next y SHALL equal the two-slot partial sum, compared against the bench model.
